// File: rtl/dm_bytelane_pipe.sv
// Byte-lane data memory: single-port RAM behind a valid/ready request port, sized/signed loads, fault checks.
// Response READ_LAT cycles after accept, one request per cycle; ReqReady drops only during reset.
module dm_bytelane_pipe #(
  parameter int    DEPTH     = 1024,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        RspValid,
  output logic        RspErr,
  output logic [31:0] DataOut
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic          accept;
  logic          fault;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic [31:0]   rdWord;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadData;
  logic [31:0]   rspData;

  logic [READ_LAT-1:0] stVld;
  logic [READ_LAT-1:0] stErr;
  logic [31:0]         stDat [READ_LAT];

  assign wordIdx = Addr[AW+1:2];
  assign lane    = Addr[1:0];
  assign accept  = ReqValid && ReqReady && ResetN;

  always_comb begin
    fault = 1'b0;
    case (ReqSize)
      2'b01:   fault = Addr[0];
      2'b10:   fault = |Addr[1:0];
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (|Addr[31:AW+2]) fault = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byteEn = 4'b0000;
    wrData = 32'h0;
    case (ReqSize)
      2'b00: begin
        byteEn = 4'b0001 << lane;
        wrData = {4{DataIn[7:0]}};
      end
      2'b01: begin
        byteEn = lane[1] ? 4'b1100 : 4'b0011;
        wrData = {2{DataIn[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = DataIn;
      end
    endcase
  end

  assign rdWord = mem[wordIdx];

  always_comb begin
    byteSel = rdWord[7:0];
    case (lane)
      2'd1:    byteSel = rdWord[15:8];
      2'd2:    byteSel = rdWord[23:16];
      2'd3:    byteSel = rdWord[31:24];
      default: byteSel = rdWord[7:0];
    endcase
    halfSel = lane[1] ? rdWord[31:16] : rdWord[15:0];
    case (ReqSize)
      2'b00:   loadData = {{24{ReqSigned & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{ReqSigned & halfSel[15]}}, halfSel};
      default: loadData = rdWord;
    endcase
    rspData = (ReqWrite || fault) ? 32'h0 : loadData;
  end

  always_ff @(posedge Clk) begin
    if (accept && ReqWrite && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      ReqReady <= 1'b0;
      stVld    <= '0;
      stErr    <= '0;
      for (int i = 0; i < READ_LAT; i++) stDat[i] <= 32'h0;
    end else begin
      ReqReady <= 1'b1;
      stVld[0] <= accept;
      stErr[0] <= accept && fault;
      stDat[0] <= accept ? rspData : 32'h0;
      for (int i = 1; i < READ_LAT; i++) begin
        stVld[i] <= stVld[i-1];
        stErr[i] <= stErr[i-1];
        stDat[i] <= stDat[i-1];
      end
    end
  end

  assign RspValid = stVld[READ_LAT-1];
  assign RspErr   = stErr[READ_LAT-1];
  assign DataOut  = stDat[READ_LAT-1];

endmodule
